// File: rtl/cp0_ctrl.sv
// Coprocessor-0 exception/interrupt controller at the M stage: SR, Cause, EPC, PRId,
// IntReq/ExcReq flush generation, and mfc0/mtc0/eret servicing.
module cp0_ctrl #(
  parameter logic [31:0] PRID_VAL = 32'h2020_0707
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0WD,
  input  logic        CP0We,
  input  logic        EXLClr,
  input  logic [31:0] PC_M,
  input  logic        BorJ_M,
  input  logic [6:2]  ExcCode_M,
  input  logic [7:2]  HWInt,
  output logic        IntReq,
  output logic        ExcReq,
  output logic [31:0] EPC,
  output logic [31:0] CP0RD
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:2] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_victim_pc;
  logic        w_wr_sr;
  logic        w_wr_epc;

  assign w_int_req   = r_ie & ~r_exl & (|(HWInt & r_im));
  assign w_exc_req   = (ExcCode_M != 5'd0) & ~r_exl & ~w_int_req;
  assign w_req       = w_int_req | w_exc_req;
  assign w_victim_pc = BorJ_M ? (PC_M - 32'd4) : PC_M;
  assign w_wr_sr     = CP0We & ~w_req & (CP0Addr == ADDR_SR);
  assign w_wr_epc    = CP0We & ~w_req & (CP0Addr == ADDR_EPC);

  assign IntReq = w_int_req;
  assign ExcReq = w_exc_req;
  assign EPC    = {r_epc, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= HWInt;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_bd      <= BorJ_M;
        r_exccode <= w_int_req ? 5'd0 : ExcCode_M;
        r_epc     <= w_victim_pc[31:2];
      end else begin
        if (w_wr_sr) begin
          r_im  <= CP0WD[15:10];
          r_exl <= CP0WD[1];
          r_ie  <= CP0WD[0];
        end
        if (w_wr_epc)
          r_epc <= CP0WD[31:2];
        // eret clear takes precedence over an EXL bit written by a coincident mtc0
        if (EXLClr)
          r_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    CP0RD = '0;
    case (CP0Addr)
      ADDR_SR:    CP0RD = {16'b0, r_im, 8'b0, r_exl, r_ie};
      ADDR_CAUSE: CP0RD = {r_bd, 15'b0, r_ip, 3'b0, r_exccode, 2'b00};
      ADDR_EPC:   CP0RD = {r_epc, 2'b00};
      ADDR_PRID:  CP0RD = PRID_VAL;
      default:    CP0RD = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed testbench for cp0_ctrl with hand-computed expected register values.
module tb_cp0_ctrl;

  localparam logic [31:0] PRID = 32'h2020_0707;

  logic        clk;
  logic        reset;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0WD;
  logic        CP0We;
  logic        EXLClr;
  logic [31:0] PC_M;
  logic        BorJ_M;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic        ExcReq;
  logic [31:0] EPC;
  logic [31:0] CP0RD;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  cp0_ctrl #(.PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .CP0Addr(CP0Addr), .CP0WD(CP0WD), .CP0We(CP0We),
    .EXLClr(EXLClr), .PC_M(PC_M), .BorJ_M(BorJ_M), .ExcCode_M(ExcCode_M),
    .HWInt(HWInt), .IntReq(IntReq), .ExcReq(ExcReq), .EPC(EPC), .CP0RD(CP0RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    CP0Addr = a;
    #1;
    check(tag, CP0RD, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CP0We = 1'b0; EXLClr = 1'b0; ExcCode_M = 5'd0; BorJ_M = 1'b0;
  endtask

  initial begin
    reset = 1'b1; CP0Addr = 5'd0; CP0WD = '0; CP0We = 1'b0; EXLClr = 1'b0;
    PC_M = 32'h3000; BorJ_M = 1'b0; ExcCode_M = 5'd0; HWInt = 6'b0;
    step(); step();
    reset = 1'b0;
    #1;
    rd(5'd12, "rst_sr", 32'h0);
    rd(5'd13, "rst_cause", 32'h0);
    rd(5'd14, "rst_epc", 32'h0);
    rd(5'd15, "rst_prid", PRID);
    check("rst_intreq", {31'b0, IntReq}, 32'h0);
    check("rst_excreq", {31'b0, ExcReq}, 32'h0);

    // enable IE and IM[10]
    CP0We = 1'b1; CP0Addr = 5'd12; CP0WD = 32'h0000_0401;
    step();
    idle(); HWInt = 6'b000001; PC_M = 32'h3010;
    rd(5'd12, "sr_written", 32'h0000_0401);
    check("int_intreq", {31'b0, IntReq}, 32'h1);
    check("int_excreq", {31'b0, ExcReq}, 32'h0);
    step();
    rd(5'd12, "int_sr", 32'h0000_0403);
    rd(5'd14, "int_epc_rd", 32'h0000_3010);
    rd(5'd13, "int_cause", 32'h0000_0400);
    check("int_epc_out", EPC, 32'h0000_3010);
    check("int_masked", {31'b0, IntReq}, 32'h0);

    // eret with no pending interrupt
    HWInt = 6'b0; EXLClr = 1'b1;
    step();
    idle();
    rd(5'd12, "eret_sr", 32'h0000_0401);

    // exception in a delay slot
    ExcCode_M = 5'd12; PC_M = 32'h3024; BorJ_M = 1'b1;
    #1;
    check("exc_excreq", {31'b0, ExcReq}, 32'h1);
    check("exc_intreq", {31'b0, IntReq}, 32'h0);
    step();
    rd(5'd14, "exc_epc", 32'h0000_3020);
    rd(5'd13, "exc_cause", 32'h8000_0030);
    check("exc_exl_blocks", {31'b0, ExcReq}, 32'h0);
    idle();

    // clear EXL, then interrupt + exception + mtc0 EPC together
    EXLClr = 1'b1;
    step();
    idle();
    HWInt = 6'b000001; ExcCode_M = 5'd12; PC_M = 32'h4000;
    CP0We = 1'b1; CP0Addr = 5'd14; CP0WD = 32'hDEAD_BEEF;
    #1;
    check("pri_intreq", {31'b0, IntReq}, 32'h1);
    check("pri_excreq", {31'b0, ExcReq}, 32'h0);
    step();
    idle();
    rd(5'd14, "pri_epc", 32'h0000_4000);
    rd(5'd13, "pri_cause", 32'h0000_0400);

    // eret with interrupt pending: no request while EXL set
    EXLClr = 1'b1;
    #1;
    check("eret_noreq", {31'b0, IntReq}, 32'h0);
    step();
    EXLClr = 1'b0;
    rd(5'd12, "eret2_sr", 32'h0000_0401);
    check("eret2_intreq", {31'b0, IntReq}, 32'h1);

    // EXLClr coinciding with request; PC_M-4 wraps
    EXLClr = 1'b1; PC_M = 32'h0; BorJ_M = 1'b1;
    step();
    idle();
    rd(5'd12, "clr_req_sr", 32'h0000_0403);
    rd(5'd14, "wrap_epc", 32'hFFFF_FFFC);
    rd(5'd13, "wrap_cause", 32'h8000_0400);

    // mtc0 EPC without request; low bits forced to zero
    HWInt = 6'b0;
    CP0We = 1'b1; CP0Addr = 5'd14; CP0WD = 32'h1234_5677;
    step();
    idle();
    rd(5'd14, "mtc0_epc", 32'h1234_5674);

    // mtc0 SR together with EXLClr: clear wins over written EXL
    CP0We = 1'b1; CP0Addr = 5'd12; CP0WD = 32'h0000_FC03; EXLClr = 1'b1;
    step();
    idle();
    rd(5'd12, "sr_exlclr", 32'h0000_FC01);

    // Cause not writable
    CP0We = 1'b1; CP0Addr = 5'd13; CP0WD = 32'hFFFF_FFFF;
    step();
    idle();
    rd(5'd13, "cause_ro", 32'h8000_0000);
    rd(5'd3, "unused_addr", 32'h0);

    // async reset mid-cycle with EXL=1, EPC=0x3020
    ExcCode_M = 5'd12; PC_M = 32'h3024; BorJ_M = 1'b1;
    step();
    idle();
    rd(5'd14, "pre_rst_epc", 32'h0000_3020);
    HWInt = 6'b111111;
    #1;
    reset = 1'b1;
    #1;
    rd(5'd12, "arst_sr", 32'h0);
    rd(5'd13, "arst_cause", 32'h0);
    rd(5'd14, "arst_epc", 32'h0);
    check("arst_intreq", {31'b0, IntReq}, 32'h0);
    step();
    reset = 1'b0; HWInt = 6'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
